// File: rtl/x_seg7_scan_4_digit.sv
// x_seg7_scan_4_digit
// Snapshots a 16-bit counter value on a load strobe and shows it as four hex
// digits on a multiplexed common-cathode 7-segment display. A new snapshot is
// committed to the display register only at a frame boundary (the last cycle of
// a full four-digit scan), so every frame shows one coherent value.
module x_seg7_scan_4_digit #(
  parameter int SCAN_DIV = 4,     // cycles each digit is held active (2..256)
  parameter bit LZ_BLANK = 1'b1   // 1 = blank leading-zero digits 3..1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_count_15,
  input  logic i_count_14,
  input  logic i_count_13,
  input  logic i_count_12,
  input  logic i_count_11,
  input  logic i_count_10,
  input  logic i_count_9,
  input  logic i_count_8,
  input  logic i_count_7,
  input  logic i_count_6,
  input  logic i_count_5,
  input  logic i_count_4,
  input  logic i_count_3,
  input  logic i_count_2,
  input  logic i_count_1,
  input  logic i_count_0,
  input  logic i_load,
  output logic o_seg_a,
  output logic o_seg_b,
  output logic o_seg_c,
  output logic o_seg_d,
  output logic o_seg_e,
  output logic o_seg_f,
  output logic o_seg_g,
  output logic o_dig_3,
  output logic o_dig_2,
  output logic o_dig_1,
  output logic o_dig_0,
  output logic o_frame,
  output logic o_pending
);

  // Prescaler width; SCAN_DIV >= 2 guarantees at least one bit.
  localparam int              PW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0]   PRE_LAST = PW'(SCAN_DIV - 1);

  // Registered state
  logic [PW-1:0] pre_q,  pre_d;
  logic [1:0]    dig_q,  dig_d;
  logic [15:0]   shd_q,  shd_d;
  logic [15:0]   disp_q, disp_d;
  logic          pend_q, pend_d;

  // Derived combinational signals
  logic [15:0] count;
  logic        pre_last;
  logic        frame_end;
  logic [3:0]  nib;
  logic        blank_3, blank_2, blank_1;
  logic        blank;
  logic [6:0]  seg;       // bit6..0 = g..a

  assign count = {i_count_15, i_count_14, i_count_13, i_count_12,
                  i_count_11, i_count_10, i_count_9,  i_count_8,
                  i_count_7,  i_count_6,  i_count_5,  i_count_4,
                  i_count_3,  i_count_2,  i_count_1,  i_count_0};

  assign pre_last  = (pre_q == PRE_LAST);
  assign frame_end = pre_last && (dig_q == 2'd3);

  // Hex nibble to segment pattern, bit6..0 = g..a, active-high.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    case (n)
      4'h0:    hex_to_seg = 7'h3F;
      4'h1:    hex_to_seg = 7'h06;
      4'h2:    hex_to_seg = 7'h5B;
      4'h3:    hex_to_seg = 7'h4F;
      4'h4:    hex_to_seg = 7'h66;
      4'h5:    hex_to_seg = 7'h6D;
      4'h6:    hex_to_seg = 7'h7D;
      4'h7:    hex_to_seg = 7'h07;
      4'h8:    hex_to_seg = 7'h7F;
      4'h9:    hex_to_seg = 7'h6F;
      4'hA:    hex_to_seg = 7'h77;
      4'hB:    hex_to_seg = 7'h7C;
      4'hC:    hex_to_seg = 7'h39;
      4'hD:    hex_to_seg = 7'h5E;
      4'hE:    hex_to_seg = 7'h79;
      default: hex_to_seg = 7'h71;
    endcase
  endfunction

  // Next-state: prescaler/digit scan, snapshot capture and frame-boundary commit.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    pre_d  = pre_q + PW'(1);
    dig_d  = dig_q;
    shd_d  = shd_q;
    disp_d = disp_q;
    pend_d = pend_q;

    if (pre_last) begin
      pre_d = '0;
      dig_d = dig_q + 2'd1;
    end

    // A load always refreshes the shadow; the last strobe before a boundary wins.
    if (i_load) begin
      shd_d  = count;
      pend_d = 1'b1;
    end

    // At the boundary a coincident load bypasses the shadow straight to the
    // display; otherwise a waiting snapshot is committed. Nothing stays pending.
    if (frame_end) begin
      if (i_load) begin
        disp_d = count;
      end else if (pend_q) begin
        disp_d = shd_q;
      end
      pend_d = 1'b0;
    end
  end

  // State register with asynchronous active-high reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values,
    // independent of statement order.
    if (i_rst) begin
      pre_q  <= '0;
      dig_q  <= 2'd0;
      shd_q  <= 16'h0000;
      disp_q <= 16'h0000;
      pend_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      dig_q  <= dig_d;
      shd_q  <= shd_d;
      disp_q <= disp_d;
      pend_q <= pend_d;
    end
  end

  // Leading-zero blanking: digit n (3..1) is dark when nibbles n..3 are all zero.
  always_comb begin
    blank_3 = (disp_q[15:12] == 4'h0);
    blank_2 = blank_3 && (disp_q[11:8] == 4'h0);
    blank_1 = blank_2 && (disp_q[7:4]  == 4'h0);
  end

  // Select the active nibble and its blanking flag from registered state only.
  always_comb begin
    nib   = disp_q[3:0];
    blank = 1'b0;
    case (dig_q)
      2'd0: begin
        nib   = disp_q[3:0];
        blank = 1'b0;
      end
      2'd1: begin
        nib   = disp_q[7:4];
        blank = LZ_BLANK && blank_1;
      end
      2'd2: begin
        nib   = disp_q[11:8];
        blank = LZ_BLANK && blank_2;
      end
      default: begin
        nib   = disp_q[15:12];
        blank = LZ_BLANK && blank_3;
      end
    endcase
  end

  // Segment pattern for the active digit; a blanked digit drives all segments off.
  always_comb begin
    seg = blank ? 7'h00 : hex_to_seg(nib);
  end

  assign o_seg_a = seg[0];
  assign o_seg_b = seg[1];
  assign o_seg_c = seg[2];
  assign o_seg_d = seg[3];
  assign o_seg_e = seg[4];
  assign o_seg_f = seg[5];
  assign o_seg_g = seg[6];

  assign o_dig_0 = (dig_q == 2'd0);
  assign o_dig_1 = (dig_q == 2'd1);
  assign o_dig_2 = (dig_q == 2'd2);
  assign o_dig_3 = (dig_q == 2'd3);

  assign o_frame   = frame_end;
  assign o_pending = pend_q;

endmodule

// File: doc/x_seg7_scan_4_digit.md
Name: x_seg7_scan_4_digit

Overview:
- Downstream consumer of the 16-bit counter outputs.
- Snapshots the 16 count bits on a load strobe and shows the value as 4 hex digits on a multiplexed common-cathode 7-segment display.
- Scans one digit at a time from a clock prescaler, and applies the new snapshot only at a frame boundary so no frame ever shows a torn value.
- Sits between the counter and the board display connector.

Parameters:
SCAN_DIV, 4, clock cycles each digit is held active (legal range 2..256)
LZ_BLANK, 1, 1 = blank leading-zero digits 3..1; 0 = always show all four digits

Ports:
i_clk  input  1  clock
i_rst  input  1  asynchronous reset, active-high
i_count_15 .. i_count_0  input  1 each  counter value bits, 15 = MSB
i_load  input  1  snapshot strobe, sampled on rising i_clk
o_seg_a .. o_seg_g  output  1 each  segment drives, active-high
o_dig_3 .. o_dig_0  output  1 each  digit enables, one-hot, active-high
o_frame  output  1  high during the last cycle of a full scan
o_pending  output  1  a snapshot is waiting for the next frame boundary

Behaviour:
- State:
  - prescaler pre_q, width clog2(SCAN_DIV)
  - digit index dig_q, 2 bits
  - shadow register shd_q, 16 bits
  - display register disp_q, 16 bits
  - flag pend_q
- Reset, asynchronous, on i_rst high: pre_q=0, dig_q=0, shd_q=0, disp_q=0, pend_q=0. Outputs during and after reset: o_dig_0=1, other o_dig=0, segments show "0" (a..f=1, g=0), o_frame=0, o_pending=0. Reset mid-scan aborts the frame immediately; any pending snapshot is lost.
- Prescaler: pre_q increments each cycle. At pre_q==SCAN_DIV-1 it wraps to 0 and dig_q advances 0->1->2->3->0.
- Frame boundary: pre_q==SCAN_DIV-1 and dig_q==3. o_frame is combinational from state and is high exactly then, i.e. 1 cycle per 4*SCAN_DIV cycles.
- Load: i_load=1 at an edge sets shd_q<=i_count[15:0] and pend_q<=1. Back-to-back loads overwrite shd_q; the last one wins.
- At the closing edge of a frame boundary:
  - if pend_q=1: disp_q<=shd_q and pend_q<=0.
  - if i_load=1 on that same edge: disp_q<=i_count directly (bypass), shd_q<=i_count, pend_q<=0.
- Digit select: o_dig_n = (dig_q==n). Exactly one is high at all times outside reset.
- Nibble shown: disp_q[4*dig_q+3 : 4*dig_q]; digit 0 = LSB nibble.
- Hex decode, bit6..0 = g..a:
  - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
  - 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71
- Blanking (LZ_BLANK=1): digit n in 3..1 is blanked when disp_q nibbles n..3 are all zero. A blanked digit drives all segments 0, but o_dig still scans normally. Digit 0 is never blanked.
- Segments and digit enables are combinational from registered state only, with no path from the i_ inputs. Latency from i_load to display is 1 to 4*SCAN_DIV cycles; i_count is not otherwise observed.

Test Plan:
- Reset then release, SCAN_DIV=4, no load -> o_dig sequence 0001,0010,0100,1000, each held 4 cycles. o_frame pulses on cycles 15, 31, ... counting from the first edge after release. Digit 0 shows 0x3F; digits 1..3 have segments 0.
- i_load with count=0x1A2F at cycle 3 -> o_pending=1 from cycle 4 through cycle 15. After the cycle-15 edge, disp=0x1A2F and o_pending=0. Next frame shows seg 0x71,0x5B,0x77,0x06 on digits 0..3.
- i_load with 0x00C5 -> digits 0,1 show 0x6D,0x39; digits 2,3 blanked. Repeat with LZ_BLANK=0 -> digits 2,3 show 0x3F.
- Loads of 0x1111 at cycle 5 then 0x2222 at cycle 9 -> after the frame boundary, disp=0x2222; no frame ever shows 0x1111.
- i_load with 0xBEEF coincident with the frame-boundary cycle, pend_q=1 holding 0x1234 -> disp=0xBEEF, o_pending=0.
- i_rst asserted asynchronously mid-digit-2 with a load pending -> outputs return to reset values immediately; after release disp=0 and o_pending=0.
